// File: rtl/aes_pkg.sv
// Shared constants, row-offset/byte-position helpers and beat control record for aes_shift_rows_pipe.
// Build option AES_SHIFT_ROWS_BYPASS_EN adds a bypass flag to the beat record.
package aes_pkg;

    localparam int NB_128 = 4;
    localparam int NB_192 = 6;
    localparam int NB_256 = 8;

    function automatic int shift_offset(input int nb, input int row);
        int off;
        case (row)
            0:       off = 0;
            1:       off = 1;
            2:       off = (nb == NB_256) ? 3 : 2;
            3:       off = (nb == NB_256) ? 4 : 3;
            default: off = 0;
        endcase
        return off;
    endfunction

    // Byte (r,c) sits column-major with byte 0 in the MSBs of the state word.
    function automatic int byte_lsb(input int nb, input int row, input int col);
        return 32 * nb - 8 - 8 * (4 * col + row);
    endfunction

`ifdef AES_SHIFT_ROWS_BYPASS_EN
    typedef struct packed {
        logic bypass;
        logic inv;
    } beat_ctl_t;
`else
    typedef struct packed {
        logic inv;
    } beat_ctl_t;
`endif

endpackage

// File: rtl/aes_pipe_stage.sv
// One valid/ready register slice; loads when empty or when the downstream side accepts.
module aes_pipe_stage #(
    parameter int PW = 129
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_valid,
    input  logic [PW-1:0] i_data,
    input  logic          i_ready,
    output logic          o_valid,
    output logic [PW-1:0] o_data
);

    logic          r_valid;
    logic [PW-1:0] r_data;
    logic          w_load;

    assign w_load = !r_valid || i_ready;

    // Stage register; payload only captured with a real beat so idle slots keep the last value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (w_load) begin
            r_valid <= i_valid;
            if (i_valid) begin
                r_data <= i_data;
            end
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;

endmodule

// File: rtl/aes_shift_rows_pipe.sv
// Pipelined ShiftRows/InvShiftRows for Nb = 4/6/8 with a valid/ready stream on both sides.
// Build option AES_SHIFT_ROWS_BYPASS_EN adds in_bypass/out_bypass for unpermuted pass-through.
module aes_shift_rows_pipe
    import aes_pkg::*;
#(
    parameter  int NB     = 4,
    parameter  int STAGES = 1,
    localparam int W      = 32 * NB
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         in_inv,
`ifdef AES_SHIFT_ROWS_BYPASS_EN
    input  logic         in_bypass,
    output logic         out_bypass,
`endif
    input  logic [W-1:0] in_state,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         out_inv,
    output logic [W-1:0] out_state,
    output logic         busy
);

    localparam int PW = W + $bits(beat_ctl_t);

    if (!(NB == NB_128 || NB == NB_192 || NB == NB_256)) begin : g_bad_nb
        $error("aes_shift_rows_pipe: NB must be 4, 6 or 8");
    end
    if (STAGES < 1 || STAGES > 4) begin : g_bad_stages
        $error("aes_shift_rows_pipe: STAGES must be 1 to 4");
    end

    logic [W-1:0] w_fwd;
    logic [W-1:0] w_inv;
    logic [W-1:0] w_perm;
    beat_ctl_t    w_in_ctl;
    beat_ctl_t    w_out_ctl;

    for (genvar r = 0; r < 4; r++) begin : g_row
        for (genvar c = 0; c < NB; c++) begin : g_col
            localparam int S   = shift_offset(NB, r);
            localparam int DST = byte_lsb(NB, r, c);
            assign w_fwd[DST +: 8] = in_state[byte_lsb(NB, r, (c + S) % NB) +: 8];
            assign w_inv[DST +: 8] = in_state[byte_lsb(NB, r, (c + NB - S) % NB) +: 8];
        end
    end

    // Direction select and control record for the incoming beat.
    always_comb begin
        w_in_ctl     = '0;
        w_in_ctl.inv = in_inv;
        w_perm       = in_state;
`ifdef AES_SHIFT_ROWS_BYPASS_EN
        w_in_ctl.bypass = in_bypass;
        if (in_bypass) begin
            w_perm = in_state;
        end else if (in_inv) begin
            w_perm = w_inv;
        end else begin
            w_perm = w_fwd;
        end
`else
        if (in_inv) begin
            w_perm = w_inv;
        end else begin
            w_perm = w_fwd;
        end
`endif
    end

    logic [STAGES:0] w_valid;
    logic [STAGES:0] w_load;
    logic [PW-1:0]   w_data [STAGES+1];

    assign w_valid[0] = in_valid;
    assign w_data[0]  = {w_in_ctl, w_perm};

    // Backpressure: a slot can load if it, or any slot after it, is empty, or the sink accepts.
    always_comb begin
        w_load         = '0;
        w_load[STAGES] = out_ready;
        for (int k = STAGES - 1; k >= 0; k--) begin
            w_load[k] = !w_valid[k+1] || w_load[k+1];
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        aes_pipe_stage #(.PW(PW)) u_stage (
            .clk     (clk),
            .rst_n   (rst_n),
            .i_valid (w_valid[k]),
            .i_data  (w_data[k]),
            .i_ready (w_load[k+1]),
            .o_valid (w_valid[k+1]),
            .o_data  (w_data[k+1])
        );
    end

    assign in_ready               = w_load[0];
    assign out_valid              = w_valid[STAGES];
    assign {w_out_ctl, out_state} = w_data[STAGES];
    assign out_inv                = w_out_ctl.inv;
    assign busy                   = |w_valid[STAGES:1];
`ifdef AES_SHIFT_ROWS_BYPASS_EN
    assign out_bypass             = w_out_ctl.bypass;
`endif

endmodule

// File: tb/tb_aes_shift_rows_pipe.sv
// Directed bench for aes_shift_rows_pipe: NB=4/STAGES=2, NB=8/STAGES=1 and NB=6/STAGES=3 instances.
module tb_aes_shift_rows_pipe;

    localparam logic [127:0] VEC_A = 128'hd42711aee0bf98f1b8b45de51e415230;
    localparam logic [127:0] VEC_B = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
    localparam logic [255:0] ASC8  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [255:0] FWD8  = 256'h00050e13_04091217_080d161b_0c111a1f_10151e03_14190207_181d060b_1c010a0f;
    localparam logic [191:0] ASC6  = 192'h000102030405060708090a0b0c0d0e0f1011121314151617;
    localparam logic [191:0] FWD6  = 192'h00050a0f_04090e13_080d1217_0c111603_10150207_1401060b;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    logic a_in_valid, a_in_ready, a_in_inv, a_out_valid, a_out_ready, a_out_inv, a_busy;
    logic [127:0] a_in_state, a_out_state;
    logic b_in_valid, b_in_ready, b_in_inv, b_out_valid, b_out_ready, b_out_inv, b_busy;
    logic [255:0] b_in_state, b_out_state;
    logic c_in_valid, c_in_ready, c_in_inv, c_out_valid, c_out_ready, c_out_inv, c_busy;
    logic [191:0] c_in_state, c_out_state;
`ifdef AES_SHIFT_ROWS_BYPASS_EN
    logic a_in_bypass, a_out_bypass, b_in_bypass, b_out_bypass, c_in_bypass, c_out_bypass;
`endif

    aes_shift_rows_pipe #(.NB(4), .STAGES(2)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready), .in_inv(a_in_inv),
`ifdef AES_SHIFT_ROWS_BYPASS_EN
        .in_bypass(a_in_bypass), .out_bypass(a_out_bypass),
`endif
        .in_state(a_in_state), .out_valid(a_out_valid), .out_ready(a_out_ready),
        .out_inv(a_out_inv), .out_state(a_out_state), .busy(a_busy)
    );

    aes_shift_rows_pipe #(.NB(8), .STAGES(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready), .in_inv(b_in_inv),
`ifdef AES_SHIFT_ROWS_BYPASS_EN
        .in_bypass(b_in_bypass), .out_bypass(b_out_bypass),
`endif
        .in_state(b_in_state), .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_inv(b_out_inv), .out_state(b_out_state), .busy(b_busy)
    );

    aes_shift_rows_pipe #(.NB(6), .STAGES(3)) dut_c (
        .clk(clk), .rst_n(rst_n), .in_valid(c_in_valid), .in_ready(c_in_ready), .in_inv(c_in_inv),
`ifdef AES_SHIFT_ROWS_BYPASS_EN
        .in_bypass(c_in_bypass), .out_bypass(c_out_bypass),
`endif
        .in_state(c_in_state), .out_valid(c_out_valid), .out_ready(c_out_ready),
        .out_inv(c_out_inv), .out_state(c_out_state), .busy(c_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic out_valid_of(input int which);
        case (which)
            0:       return a_out_valid;
            1:       return b_out_valid;
            default: return c_out_valid;
        endcase
    endfunction

    // Drives one beat into an idle instance and waits (bounded) for it at the output.
    task automatic send(input int which, input logic [255:0] st, input logic inv,
                        output logic [255:0] got, output logic got_inv, output int lat);
        @(posedge clk); #1;
        case (which)
            0: begin a_in_state = st[127:0]; a_in_inv = inv; a_in_valid = 1'b1; a_out_ready = 1'b1; end
            1: begin b_in_state = st;        b_in_inv = inv; b_in_valid = 1'b1; b_out_ready = 1'b1; end
            default: begin c_in_state = st[191:0]; c_in_inv = inv; c_in_valid = 1'b1; c_out_ready = 1'b1; end
        endcase
        @(posedge clk); #1;
        a_in_valid = 1'b0; b_in_valid = 1'b0; c_in_valid = 1'b0;
        lat = 1;
        while (!out_valid_of(which) && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
        got = '0;
        case (which)
            0: begin got[127:0] = a_out_state; got_inv = a_out_inv; end
            1: begin got        = b_out_state; got_inv = b_out_inv; end
            default: begin got[191:0] = c_out_state; got_inv = c_out_inv; end
        endcase
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        n_checks += 12;
        if (a_out_valid !== 1'b0 || b_out_valid !== 1'b0 || c_out_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_out_valid got %b%b%b expected 000", a_out_valid, b_out_valid, c_out_valid);
        end
        if (a_busy !== 1'b0 || b_busy !== 1'b0 || c_busy !== 1'b0) begin
            n_fail++; $display("FAIL reset_busy got %b%b%b expected 000", a_busy, b_busy, c_busy);
        end
        if (a_out_inv !== 1'b0 || b_out_inv !== 1'b0 || c_out_inv !== 1'b0) begin
            n_fail++; $display("FAIL reset_out_inv got %b%b%b expected 000", a_out_inv, b_out_inv, c_out_inv);
        end
        if (a_out_state !== 128'h0) begin n_fail++; $display("FAIL reset_state_a got %h expected 0", a_out_state); end
        if (b_out_state !== 256'h0) begin n_fail++; $display("FAIL reset_state_b got %h expected 0", b_out_state); end
        if (c_out_state !== 192'h0) begin n_fail++; $display("FAIL reset_state_c got %h expected 0", c_out_state); end
        #3 rst_n = 1'b1;
        #1;
        if (a_in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready_a got %b expected 1", a_in_ready); end
        if (b_in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready_b got %b expected 1", b_in_ready); end
        if (c_in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready_c got %b expected 1", c_in_ready); end
        if (a_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy_post got %b expected 0", a_busy); end
        if (b_out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_b_valid_post got %b expected 0", b_out_valid); end
        if (c_out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_c_valid_post got %b expected 0", c_out_valid); end
    endtask

    task automatic test_nb4();
        logic [255:0] got;
        logic         gi;
        int           lat;
        send(0, {128'h0, VEC_A}, 1'b0, got, gi, lat);
        n_checks += 3;
        if (got[127:0] !== VEC_B) begin n_fail++; $display("FAIL fwd4_state got %h expected %h", got[127:0], VEC_B); end
        if (gi !== 1'b0) begin n_fail++; $display("FAIL fwd4_inv got %b expected 0", gi); end
        if (lat !== 2) begin n_fail++; $display("FAIL fwd4_latency got %0d expected 2", lat); end
        send(0, {128'h0, VEC_B}, 1'b1, got, gi, lat);
        n_checks += 3;
        if (got[127:0] !== VEC_A) begin n_fail++; $display("FAIL inv4_state got %h expected %h", got[127:0], VEC_A); end
        if (gi !== 1'b1) begin n_fail++; $display("FAIL inv4_inv got %b expected 1", gi); end
        if (lat !== 2) begin n_fail++; $display("FAIL inv4_latency got %0d expected 2", lat); end
    endtask

    task automatic test_nb8();
        logic [255:0] got;
        logic         gi;
        int           lat;
        send(1, ASC8, 1'b0, got, gi, lat);
        n_checks += 2;
        if (got !== FWD8) begin n_fail++; $display("FAIL fwd8_state got %h expected %h", got, FWD8); end
        if (lat !== 1) begin n_fail++; $display("FAIL fwd8_latency got %0d expected 1", lat); end
        send(1, FWD8, 1'b1, got, gi, lat);
        n_checks += 2;
        if (got !== ASC8) begin n_fail++; $display("FAIL inv8_state got %h expected %h", got, ASC8); end
        if (gi !== 1'b1) begin n_fail++; $display("FAIL inv8_inv got %b expected 1", gi); end
    endtask

    task automatic test_nb6();
        logic [255:0] got;
        logic         gi;
        int           lat;
        send(2, {64'h0, ASC6}, 1'b0, got, gi, lat);
        n_checks += 2;
        if (got[191:0] !== FWD6) begin n_fail++; $display("FAIL fwd6_state got %h expected %h", got[191:0], FWD6); end
        if (lat !== 3) begin n_fail++; $display("FAIL fwd6_latency got %0d expected 3", lat); end
        send(2, {64'h0, FWD6}, 1'b1, got, gi, lat);
        n_checks += 1;
        if (got[191:0] !== ASC6) begin n_fail++; $display("FAIL inv6_state got %h expected %h", got[191:0], ASC6); end
    endtask

    task automatic test_back_to_back();
        logic [127:0] exp_q [10];
        logic [127:0] beat;
        logic [127:0] prev_state;
        logic         prev_inv, have_prev, seen_drop, seen_both, in_x, out_x;
        int           n_in, n_out, occ;
        for (int i = 0; i < 10; i++) begin
            beat = (i % 2 == 0) ? VEC_B : VEC_A;
            beat[127:120] = 8'(i);
            exp_q[i] = beat;
        end
        n_in = 0; n_out = 0; occ = 0;
        have_prev = 1'b0; seen_drop = 1'b0; seen_both = 1'b0;
        prev_state = '0; prev_inv = 1'b0;
        for (int cyc = 0; cyc < 60 && n_out < 10; cyc++) begin
            @(posedge clk); #1;
            a_out_ready = !(cyc >= 3 && cyc <= 7);
            a_in_valid  = (n_in < 10);
            a_in_inv    = (n_in % 2 == 1);
            beat        = (n_in % 2 == 0) ? VEC_A : VEC_B;
            beat[127:120] = 8'(n_in);
            a_in_state  = beat;
            #4;
            in_x  = a_in_valid && a_in_ready;
            out_x = a_out_valid && a_out_ready;
            if (!a_in_ready && !seen_drop && n_in < 10) begin
                seen_drop = 1'b1;
                n_checks++;
                if (occ !== 2) begin n_fail++; $display("FAIL stall_drop_occupancy got %0d expected 2", occ); end
            end
            if (a_out_valid && !a_out_ready) begin
                if (have_prev) begin
                    n_checks++;
                    if (a_out_state !== prev_state || a_out_inv !== prev_inv) begin
                        n_fail++; $display("FAIL stall_hold got %h/%b expected %h/%b", a_out_state, a_out_inv, prev_state, prev_inv);
                    end
                end
                prev_state = a_out_state; prev_inv = a_out_inv; have_prev = 1'b1;
            end else begin
                have_prev = 1'b0;
            end
            if (out_x) begin
                n_checks++;
                if (n_out >= 10) begin
                    n_fail++; $display("FAIL stream_extra_beat got %h expected none", a_out_state);
                end else if (a_out_state !== exp_q[n_out] || a_out_inv !== (n_out % 2 == 1)) begin
                    n_fail++; $display("FAIL stream_beat%0d got %h/%b expected %h/%b", n_out, a_out_state, a_out_inv, exp_q[n_out], (n_out % 2 == 1));
                end
                n_out++;
            end
            if (in_x && out_x && occ == 2) seen_both = 1'b1;
            if (in_x) n_in++;
            occ = occ + (in_x ? 1 : 0) - (out_x ? 1 : 0);
        end
        @(posedge clk); #1;
        a_in_valid = 1'b0; a_out_ready = 1'b1;
        n_checks += 4;
        if (n_out !== 10) begin n_fail++; $display("FAIL stream_delivered got %0d expected 10", n_out); end
        if (n_in !== 10) begin n_fail++; $display("FAIL stream_accepted got %0d expected 10", n_in); end
        if (seen_drop !== 1'b1) begin n_fail++; $display("FAIL stream_in_ready_drop got %b expected 1", seen_drop); end
        if (seen_both !== 1'b1) begin n_fail++; $display("FAIL stream_simultaneous got %b expected 1", seen_both); end
    endtask

    task automatic test_reset_midstream();
        logic [255:0] got;
        logic         gi;
        int           lat;
        @(posedge clk); #1;
        a_out_ready = 1'b0; a_in_valid = 1'b1; a_in_state = VEC_A; a_in_inv = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        a_in_valid = 1'b0;
        n_checks += 2;
        if (a_busy !== 1'b1 || a_out_valid !== 1'b1) begin
            n_fail++; $display("FAIL midrst_full got busy=%b valid=%b expected 1/1", a_busy, a_out_valid);
        end
        if (a_in_ready !== 1'b0) begin n_fail++; $display("FAIL midrst_in_ready_full got %b expected 0", a_in_ready); end
        #2 rst_n = 1'b0;
        #1;
        n_checks += 3;
        if (a_out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_out_valid got %b expected 0", a_out_valid); end
        if (a_busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy got %b expected 0", a_busy); end
        if (a_out_state !== 128'h0) begin n_fail++; $display("FAIL midrst_state got %h expected 0", a_out_state); end
        #3 rst_n = 1'b1;
        a_out_ready = 1'b1;
        #1;
        n_checks++;
        if (a_in_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_in_ready got %b expected 1", a_in_ready); end
        send(0, {128'h0, VEC_B}, 1'b1, got, gi, lat);
        n_checks += 2;
        if (got[127:0] !== VEC_A || gi !== 1'b1) begin
            n_fail++; $display("FAIL midrst_first_beat got %h/%b expected %h/1", got[127:0], gi, VEC_A);
        end
        if (lat !== 2) begin n_fail++; $display("FAIL midrst_latency got %0d expected 2", lat); end
    endtask

`ifdef AES_SHIFT_ROWS_BYPASS_EN
    task automatic test_bypass();
        logic [255:0] got;
        logic         gi;
        int           lat;
        a_in_bypass = 1'b1;
        send(0, {128'h0, VEC_A}, 1'b1, got, gi, lat);
        n_checks += 3;
        if (got[127:0] !== VEC_A) begin n_fail++; $display("FAIL bypass_state got %h expected %h", got[127:0], VEC_A); end
        if (a_out_bypass !== 1'b1) begin n_fail++; $display("FAIL bypass_flag got %b expected 1", a_out_bypass); end
        if (lat !== 2) begin n_fail++; $display("FAIL bypass_latency got %0d expected 2", lat); end
        a_in_bypass = 1'b0;
    endtask
`endif

    initial begin
        n_checks = 0; n_fail = 0;
        a_in_valid = 1'b0; a_in_inv = 1'b0; a_in_state = '0; a_out_ready = 1'b1;
        b_in_valid = 1'b0; b_in_inv = 1'b0; b_in_state = '0; b_out_ready = 1'b1;
        c_in_valid = 1'b0; c_in_inv = 1'b0; c_in_state = '0; c_out_ready = 1'b1;
`ifdef AES_SHIFT_ROWS_BYPASS_EN
        a_in_bypass = 1'b0; b_in_bypass = 1'b0; c_in_bypass = 1'b0;
`endif
        test_reset();
        test_nb4();
        test_nb8();
        test_nb6();
        test_back_to_back();
        test_reset_midstream();
`ifdef AES_SHIFT_ROWS_BYPASS_EN
        test_bypass();
`endif
        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
